dom_classifier: RTL and testbench
=================================

# dom_classifier

Final-stage reader for the classification output memory (DOM). After the step-2 stage has written its eight ReLU-clipped 16-bit class scores to DOM addresses 0–7, the controller pulses `start`. This block then reads the eight words back, finds the arg-max, and reports the winning class index, its score and a tie flag. It closes the chain controller → step-2 writer → DOM SRAM → classifier.

## Interface

Parameters:
- `RD_LAT`, default 1: DOM SRAM read latency in cycles, from address/enable to data valid. Legal range 1–3.
- `N_CLASS`, default 8: number of class scores. Fixed at 8; address width is 3.
- `DATA_W`, default 16: score width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  controller request. Sampled only in IDLE.
- `dom_read_en`  out  1  DOM SRAM read enable.
- `dom_read_addr`  out  3  DOM SRAM read address.
- `dom_read_data`  in  16  DOM SRAM read data, valid `RD_LAT` cycles after the address.
- `busy`  out  1  high from the first issue cycle through the finish cycle.
- `finish`  out  1  single-cycle completion pulse to the controller.
- `result_valid`  out  1  high from the finish cycle until the next accepted `start` or `reset`.
- `class_idx`  out  3  winning class index.
- `class_val`  out  16  winning score.
- `tie_flag`  out  1  high when another class equals the winning score.

## Operation

- FSM has four states: IDLE → ISSUE → DRAIN → DONE → IDLE.
  - IDLE: `start`=1 moves to ISSUE, clears `result_valid`, `class_idx`, `class_val`, `tie_flag` and the issue counter.
  - ISSUE: drives `dom_read_en`=1 with `dom_read_addr` 0,1,…,7 on consecutive cycles. Moves to DRAIN after address 7.
  - DRAIN: waits until the tag pipeline is empty, i.e. all 8 words have been sampled.
  - DONE: lasts one cycle. Asserts `finish`=1 and sets `result_valid`=1, then returns to IDLE.
- Tag pipeline: a shift register of depth `RD_LAT` carries {valid, index} for each issued read. Returned data is processed only when the pipeline output is valid.
- Compare rule: scores are unsigned 16-bit.
  - First returned word (index 0) loads max and index and clears the tie.
  - For later words: data > max updates max and index and clears the tie. Data == max sets the tie and keeps the lower index. Data < max changes nothing.
- `start` in ISSUE, DRAIN or DONE is ignored, with no queuing.
- `dom_read_addr` is 0 and `dom_read_en` is 0 outside ISSUE.
- Reset values are 0 for every output.
- Reset mid-operation: the FSM goes to IDLE and the tag pipeline is cleared. In-flight read data is discarded and no `finish` is produced.

## Timing

- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..8: `dom_read_en`=1, `dom_read_addr`=k at cycle 1+k. `busy` is high from cycle 1.
- Data for address k is sampled at the end of cycle 1+k+`RD_LAT`. The last sample is at cycle 8+`RD_LAT`.
- Cycle 9+`RD_LAT`: `finish`=1, `result_valid`=1, and `class_idx`, `class_val` and `tie_flag` are final. `busy` drops after this cycle.
- Total latency from start to finish is 9+`RD_LAT` cycles: 10 with the default.
- `start` is accepted again from cycle 10+`RD_LAT`, in which case the next issue begins at cycle 11+`RD_LAT`.
- Result outputs hold their value, unchanged, while in IDLE with `result_valid`=1.

## Test plan

- Distinct scores [5,100,7,3,0,99,2,1], `RD_LAT`=1 → reads issued at addresses 0–7 in cycles 1–8. `finish` pulses in cycle 10 with `class_idx`=1, `class_val`=100, `tie_flag`=0.
- All scores 0 (every class clipped by ReLU) → `class_idx`=0, `class_val`=0, `tie_flag`=1.
- Scores [10,40,40,3,3,3,3,3] → `class_idx`=1, `class_val`=40, `tie_flag`=1.
- Scores 0x7FFF at addresses 0–6 and 0xFFFF at address 7 → `class_idx`=7, `class_val`=0xFFFF (confirms unsigned compare).
- `reset` asserted in cycle 5 of a run, then `start` in cycle 7 → no `finish` for the aborted run, all outputs 0 during the gap. The new run produces `finish` in cycle 17 with the correct result.
- `RD_LAT`=2, with `start` re-pulsed in cycles 3 and 11 → both extra pulses ignored. Single `finish` in cycle 11, `busy` high for cycles 1–11.

Source files
------------

// File: rtl/dom_classifier.sv
// Reads the eight class scores back from the DOM SRAM and reports the arg-max.
// Ties keep the lowest index and raise tie_flag.
module dom_classifier #(
  parameter int RD_LAT  = 1,
  parameter int N_CLASS = 8,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              dom_read_en,
  output logic [2:0]        dom_read_addr,
  input  logic [DATA_W-1:0] dom_read_data,
  output logic              busy,
  output logic              finish,
  output logic              result_valid,
  output logic [2:0]        class_idx,
  output logic [DATA_W-1:0] class_val,
  output logic              tie_flag
);

  localparam logic [2:0] LAST_IDX = 3'(N_CLASS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [2:0]        cnt_r;
  logic              tag_vld_r [RD_LAT];
  logic [2:0]        tag_idx_r [RD_LAT];
  logic              pending_s;
  logic              issue_s;
  logic              accept_s;
  logic              result_valid_r;
  logic [2:0]        class_idx_r;
  logic [DATA_W-1:0] class_val_r;
  logic              tie_flag_r;
  logic              ret_vld_s;
  logic [2:0]        ret_idx_s;

  assign ret_vld_s = tag_vld_r[RD_LAT-1];
  assign ret_idx_s = tag_idx_r[RD_LAT-1];

  // The last pipeline stage is consumed this cycle, so only earlier stages keep DRAIN alive.
  always_comb begin
    state_s   = state_r;
    issue_s   = 1'b0;
    accept_s  = 1'b0;
    pending_s = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pending_s = pending_s | tag_vld_r[i];
    end
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = ISSUE;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        issue_s = 1'b1;
        if (cnt_r == LAST_IDX) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (!pending_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  always_comb begin
    dom_read_en   = issue_s;
    dom_read_addr = issue_s ? cnt_r : 3'd0;
    busy          = (state_r != IDLE);
    finish        = (state_r == DONE);
    result_valid  = result_valid_r;
    class_idx     = class_idx_r;
    class_val     = class_val_r;
    tie_flag      = tie_flag_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      cnt_r          <= 3'd0;
      result_valid_r <= 1'b0;
      class_idx_r    <= 3'd0;
      class_val_r    <= '0;
      tie_flag_r     <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_r[i] <= 1'b0;
        tag_idx_r[i] <= 3'd0;
      end
    end else begin
      state_r <= state_s;

      if (accept_s) begin
        cnt_r <= 3'd0;
      end else if (issue_s) begin
        cnt_r <= cnt_r + 3'd1;
      end

      tag_vld_r[0] <= issue_s;
      tag_idx_r[0] <= cnt_r;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_idx_r[i] <= tag_idx_r[i-1];
      end

      if (accept_s) begin
        result_valid_r <= 1'b0;
        class_idx_r    <= 3'd0;
        class_val_r    <= '0;
        tie_flag_r     <= 1'b0;
      end else begin
        if (state_r == DRAIN && state_s == DONE) begin
          result_valid_r <= 1'b1;
        end
        // Strictly greater wins, so equal scores keep the earlier index.
        if (ret_vld_s) begin
          if (ret_idx_s == 3'd0) begin
            class_val_r <= dom_read_data;
            class_idx_r <= 3'd0;
            tie_flag_r  <= 1'b0;
          end else if (dom_read_data > class_val_r) begin
            class_val_r <= dom_read_data;
            class_idx_r <= ret_idx_s;
            tie_flag_r  <= 1'b0;
          end else if (dom_read_data == class_val_r) begin
            tie_flag_r <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dom_classifier.sv
// Randomized self-checking bench: two classifiers (read latency 1 and 2), each fed by an SRAM model.
module tb_dom_classifier;

  logic        clk = 1'b0;
  logic        reset  [2];
  logic        start  [2];
  logic        rd_en  [2];
  logic [2:0]  rd_addr[2];
  logic [15:0] rd_data[2];
  logic        busy   [2];
  logic        finish [2];
  logic        rv     [2];
  logic [2:0]  idx    [2];
  logic [15:0] val    [2];
  logic        tie    [2];

  logic [15:0] mem [2][8];
  logic [15:0] vec [8];
  logic [15:0] q0;
  logic [15:0] q1a;
  logic [15:0] q1b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dom_classifier #(.RD_LAT(1)) dut0 (
    .clk(clk), .reset(reset[0]), .start(start[0]),
    .dom_read_en(rd_en[0]), .dom_read_addr(rd_addr[0]), .dom_read_data(rd_data[0]),
    .busy(busy[0]), .finish(finish[0]), .result_valid(rv[0]),
    .class_idx(idx[0]), .class_val(val[0]), .tie_flag(tie[0])
  );

  dom_classifier #(.RD_LAT(2)) dut1 (
    .clk(clk), .reset(reset[1]), .start(start[1]),
    .dom_read_en(rd_en[1]), .dom_read_addr(rd_addr[1]), .dom_read_data(rd_data[1]),
    .busy(busy[1]), .finish(finish[1]), .result_valid(rv[1]),
    .class_idx(idx[1]), .class_val(val[1]), .tie_flag(tie[1])
  );

  // SRAM models; 16'hDEAD marks cycles with no read enabled
  always @(posedge clk) begin
    q0  <= rd_en[0] ? mem[0][rd_addr[0]] : 16'hDEAD;
    q1a <= rd_en[1] ? mem[1][rd_addr[1]] : 16'hDEAD;
    q1b <= q1a;
  end
  assign rd_data[0] = q0;
  assign rd_data[1] = q1b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs(input int d);
    return {5'd0, busy[d], finish[d], rv[d], tie[d], idx[d], val[d], rd_en[d], rd_addr[d]};
  endfunction

  // Reference: maximum score, lowest index holding it, tie if it occurs more than once
  task automatic model(input int d, output logic [2:0] ei, output logic [15:0] ev, output logic et);
    int n;
    ev = 16'd0;
    for (int i = 0; i < 8; i++) if (mem[d][i] > ev) ev = mem[d][i];
    n  = 0;
    ei = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mem[d][i] == ev) begin
        ei = 3'(i);
        n++;
      end
    end
    et = (n > 1);
  endtask

  task automatic load(input int d);
    for (int i = 0; i < 8; i++) mem[d][i] = vec[i];
  endtask

  // Called at a negedge; start is driven in this cycle (cycle 0)
  task automatic run(input int d, input int x1, input int x2, input string tag);
    logic [2:0]  ei;
    logic [15:0] ev;
    logic        et;
    int          cyc;
    int          lat;
    bit          done;
    lat = d + 1;
    model(d, ei, ev, et);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 40) begin
      check_eq({tag, "/en"},   32'(rd_en[d]),   32'(cyc <= 8));
      check_eq({tag, "/addr"}, 32'(rd_addr[d]), (cyc <= 8) ? 32'(cyc - 1) : 32'd0);
      check_eq({tag, "/busy"}, 32'(busy[d]),    32'd1);
      if (finish[d]) begin
        check_eq({tag, "/latency"}, 32'(cyc),    32'(9 + lat));
        check_eq({tag, "/rv"},      32'(rv[d]),  32'd1);
        check_eq({tag, "/idx"},     32'(idx[d]), 32'(ei));
        check_eq({tag, "/val"},     32'(val[d]), 32'(ev));
        check_eq({tag, "/tie"},     32'(tie[d]), 32'(et));
        done = 1'b1;
      end else begin
        check_eq({tag, "/rv_low"}, 32'(rv[d]), 32'd0);
      end
      start[d] = (cyc == x1 || cyc == x2);
      @(negedge clk);
      cyc++;
    end
    if (!done) check_eq({tag, "/timeout"}, 32'd0, 32'd1);
    start[d] = 1'b0;
    check_eq({tag, "/fin_pulse"}, 32'(finish[d]), 32'd0);
    check_eq({tag, "/busy_off"},  32'(busy[d]),   32'd0);
    check_eq({tag, "/hold"}, {10'd0, rv[d], tie[d], idx[d], val[d]}, {10'd0, 1'b1, et, ei, ev});
    @(negedge clk);
    check_eq({tag, "/no_restart"}, 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      start[d] = 1'b0;
      for (int i = 0; i < 8; i++) mem[d][i] = 16'd0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    check_eq("reset0", all_outs(0), 32'd0);
    check_eq("reset1", all_outs(1), 32'd0);

    vec = '{16'd5, 16'd100, 16'd7, 16'd3, 16'd0, 16'd99, 16'd2, 16'd1};
    load(0); run(0, 0, 0, "distinct");
    vec = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    load(0); run(0, 0, 0, "all_zero");
    vec = '{16'd10, 16'd40, 16'd40, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
    load(0); run(0, 0, 0, "tie40");
    vec = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFF};
    load(0); run(0, 0, 0, "unsigned");

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++)
        vec[i] = (t % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      load(0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(0, (t == 3) ? 3 : 0, (t == 3) ? 10 : 0, "rand0");
    end

    // Abort: reset in cycle 5, restart in cycle 7
    for (int i = 0; i < 8; i++) vec[i] = 16'($urandom);
    load(0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      check_eq("abort/no_finish", 32'(finish[0]), 32'd0);
      if (cyc == 5) reset[0] = 1'b1;
      @(negedge clk);
    end
    reset[0] = 1'b0;
    check_eq("abort/zero_c6", all_outs(0), 32'd0);
    @(negedge clk);
    check_eq("abort/zero_c7", all_outs(0), 32'd0);
    vec[6] = 16'hFFFF;
    load(0);
    run(0, 0, 0, "abort_rerun");

    // Latency 2, start re-pulsed in cycles 3 and 11
    for (int i = 0; i < 8; i++) vec[i] = 16'($urandom);
    load(1); run(1, 3, 11, "lat2_ignore");
    vec = '{16'd10, 16'd40, 16'd40, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
    load(1); run(1, 0, 0, "lat2_tie");
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++)
        vec[i] = (t % 2 == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      load(1);
      run(1, 0, 0, "rand1");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
